// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: data width, op encodings,
// FSM states and small two's-complement helpers.
package mul_div_unit_pkg;

    localparam int DATA_BUS_W = 32;
    localparam int ITER_W     = 6;

    typedef logic [DATA_BUS_W-1:0] data_bus_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic data_bus_t neg32(input data_bus_t v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of a signed operand; 0x8000_0000 maps onto itself, which is
    // the correct unsigned magnitude.
    function automatic data_bus_t mag32(input data_bus_t v, input logic is_signed);
        if (is_signed && v[31]) begin
            return neg32(v);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Radix-2 restoring divide core: 64-bit {remainder, quotient} shift register,
// latched divisor and step counter. Works on unsigned magnitudes only.
module div_iter
    import mul_div_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_load,
    input  logic      i_step,
    input  data_bus_t i_dividend,
    input  data_bus_t i_divisor,
    output data_bus_t o_quot,
    output data_bus_t o_rem,
    output logic      o_last
);

    logic [63:0]       r_acc;
    data_bus_t         r_divisor;
    logic [ITER_W-1:0] r_cnt;

    logic [32:0] w_trial;
    logic [63:0] w_acc_next;

    // One restoring step; the 33-bit trial keeps the bit shifted out of the
    // remainder so full-range unsigned divisors work.
    always_comb begin
        w_trial    = r_acc[63:31] - {1'b0, r_divisor};
        w_acc_next = {r_acc[62:0], 1'b0};
        if (!w_trial[32]) begin
            w_acc_next = {w_trial[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_acc_next = {r_acc[62:0], 1'b0};
        end
    end

    // Accumulator, divisor and counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= 64'd0;
            r_divisor <= 32'd0;
            r_cnt     <= 6'd0;
        end else if (i_load) begin
            r_acc     <= {32'd0, i_dividend};
            r_divisor <= i_divisor;
            r_cnt     <= 6'd0;
        end else if (i_step) begin
            r_acc     <= w_acc_next;
            r_cnt     <= r_cnt + 6'd1;
        end else begin
            r_acc     <= r_acc;
        end
    end

    assign o_quot = r_acc[31:0];
    assign o_rem  = r_acc[63:32];
    assign o_last = (r_cnt == 6'd31);

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing the HI/LO write pair.
// Multiplies take 2 cycles, divides 34; cancel aborts without writing HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        hilo_write_en,
    output logic [31:0] hi_write_data,
    output logic [31:0] lo_write_data
);

    state_e    r_state;
    op_e       r_op;
    data_bus_t r_a;
    data_bus_t r_b;
    logic      r_sign_a;
    logic      r_sign_b;
    logic      r_div_zero;
    logic      r_busy;
    logic      r_done;
    data_bus_t r_hi;
    data_bus_t r_lo;

    logic      w_accept;
    logic      w_is_div;
    logic      w_is_signed_div;
    logic      w_load;
    logic      w_step;
    logic      w_last;
    data_bus_t w_quot;
    data_bus_t w_rem;
    data_bus_t w_quot_fix;
    data_bus_t w_rem_fix;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    assign w_accept        = (r_state == ST_IDLE) && start && !cancel;
    assign w_is_div        = op[1];
    assign w_is_signed_div = (op == OP_DIV);
    assign w_load          = w_accept && w_is_div;
    assign w_step          = (r_state == ST_DIV) && !cancel;

    div_iter u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (mag32(src_a, w_is_signed_div)),
        .i_divisor  (mag32(src_b, w_is_signed_div)),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_last)
    );

    // Sign extension to 64 bits lets one unsigned multiply serve both
    // MULT and MULTU; the low 64 bits are correct in either case.
    always_comb begin
        w_mul_a = {32'd0, r_a};
        w_mul_b = {32'd0, r_b};
        if (r_op == OP_MULT) begin
            w_mul_a = {{32{r_a[31]}}, r_a};
            w_mul_b = {{32{r_b[31]}}, r_b};
        end else begin
            w_mul_a = {32'd0, r_a};
            w_mul_b = {32'd0, r_b};
        end
        w_prod = w_mul_a * w_mul_b;
    end

    // Sign fix-up for DIV; a zero divisor leaves the all-ones quotient intact.
    always_comb begin
        w_quot_fix = w_quot;
        w_rem_fix  = w_rem;
        if (r_op == OP_DIV) begin
            if ((r_sign_a ^ r_sign_b) && !r_div_zero) begin
                w_quot_fix = neg32(w_quot);
            end else begin
                w_quot_fix = w_quot;
            end
            if (r_sign_a) begin
                w_rem_fix = neg32(w_rem);
            end else begin
                w_rem_fix = w_rem;
            end
        end else begin
            w_quot_fix = w_quot;
            w_rem_fix  = w_rem;
        end
    end

    // Control FSM with registered busy/done and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_MULT;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else if (cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op       <= op_e'(op);
                        r_a        <= src_a;
                        r_b        <= src_b;
                        r_sign_a   <= w_is_signed_div && src_a[31];
                        r_sign_b   <= w_is_signed_div && src_b[31];
                        r_div_zero <= (src_b == 32'd0);
                        r_busy     <= 1'b1;
                        r_state    <= w_is_div ? ST_DIV : ST_MUL;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    r_hi    <= w_prod[63:32];
                    r_lo    <= w_prod[31:0];
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DIV: begin
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_rem_fix;
                    r_lo    <= w_quot_fix;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign hilo_write_en = r_done;
    assign hi_write_data = r_hi;
    assign lo_write_data = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, results, divide
// by zero, overflow wrap, cancel, busy-start rejection and mid-divide reset.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        hilo_write_en;
    logic [31:0] hi_write_data;
    logic [31:0] lo_write_data;

    int tests_run = 0;
    int tests_failed = 0;

    mul_div_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .src_a         (src_a),
        .src_b         (src_b),
        .cancel        (cancel),
        .busy          (busy),
        .done          (done),
        .hilo_write_en (hilo_write_en),
        .hi_write_data (hi_write_data),
        .lo_write_data (lo_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation in cycle 0 and follow it to its done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, " busy_c1"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
        check({tag, " wr_en"}, {31'd0, hilo_write_en}, 32'd1);
        check({tag, " hi"}, hi_write_data, exp_hi);
        check({tag, " lo"}, lo_write_data, exp_lo);
        tick();
        check({tag, " done_fall"}, {31'd0, done}, 32'd0);
        check({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, " lo_hold"}, lo_write_data, exp_lo);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00;
        src_a = 32'd0; src_b = 32'd0;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset wr_en", {31'd0, hilo_write_en}, 32'd0);
        check("reset hi", hi_write_data, 32'd0);
        check("reset lo", lo_write_data, 32'd0);
        rst = 1'b0;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFE, 32'd3,        2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100,      32'd7,        34, 32'd2, 32'd14);
        run_op("divu_by0",  2'b11, 32'd5,         32'd0,        34, 32'd5, 32'hFFFF_FFFF);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFFB, 32'd0,      34, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);

        // Cancel mid-divide; start held high while busy must be ignored.
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick();
        op = 2'b01; src_a = 32'd3; src_b = 32'd4;
        repeat (4) tick();
        start = 1'b0;
        check("busy_start_ignored", {31'd0, busy}, 32'd1);
        repeat (5) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy_c11", {31'd0, busy}, 32'd0);
        check("cancel done_c11", {31'd0, done}, 32'd0);
        check("cancel hi_kept", hi_write_data, 32'd0);
        check("cancel lo_kept", lo_write_data, 32'h8000_0000);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_write_en) cnt++;
            tick();
        end
        check("cancel no_write", cnt, 32'd0);

        run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 2, 32'd0, 32'd12);

        // Cancel and start together in IDLE: the request is dropped.
        op = 2'b01; src_a = 32'd5; src_b = 32'd5; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_start busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("cancel_start lo", lo_write_data, 32'd12);

        // Reset in cycle 20 of a divide.
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst wr_en", {31'd0, hilo_write_en}, 32'd0);
        check("rst hi", hi_write_data, 32'd0);
        check("rst lo", lo_write_data, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_write_en) cnt++;
            tick();
        end
        check("rst no_write", cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
